// File: rtl/tomasulo_pkg.sv
// Shared constants for the Tomasulo core reorder buffer.
//   ROB_DEPTH / ROB_DATA_W / ROB_REG_W / ROB_NUM_WB : default ROB geometry
//   ROB_FLAG_W                                      : per-entry status flags (valid, done, is_br, mispred)
//   CDB_ADD / CDB_MUL                               : writeback port index of each functional unit
package tomasulo_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_DATA_W = 8;
    localparam int ROB_REG_W  = 4;
    localparam int ROB_NUM_WB = 2;
    localparam int ROB_FLAG_W = 4;

    localparam int CDB_ADD = 0;
    localparam int CDB_MUL = 1;

endpackage

// File: rtl/rob_param_if.sv
// Bundle between the ROB and its neighbours (issue, CDB writeback, regbank).
//   master : issue / CDB side - drives allocations, writebacks and operand lookups
//   slave  : the ROB - returns allocation status, lookup results, commit and count
interface rob_param_if
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DATA_W = ROB_DATA_W,
    parameter int REG_W  = ROB_REG_W,
    parameter int NUM_WB = ROB_NUM_WB,
    parameter int TAG_W  = $clog2(DEPTH)
);

    logic                     alloc_valid;
    logic [REG_W-1:0]         alloc_dest;
    logic                     alloc_is_br;
    logic                     alloc_ready;
    logic [TAG_W-1:0]         alloc_tag;

    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic [NUM_WB-1:0]        wb_mispred;

    logic [TAG_W-1:0]         q_tag;
    logic                     q_ready;
    logic [DATA_W-1:0]        q_data;

    logic                     commit_valid;
    logic [REG_W-1:0]         commit_dest;
    logic [DATA_W-1:0]        commit_data;
    logic [TAG_W-1:0]         commit_tag;
    logic                     flush;
    logic [TAG_W:0]           count;

    modport master (
        output alloc_valid, alloc_dest, alloc_is_br,
        input  alloc_ready, alloc_tag,
        output wb_valid, wb_tag, wb_data, wb_mispred,
        output q_tag,
        input  q_ready, q_data,
        input  commit_valid, commit_dest, commit_data, commit_tag, flush, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, alloc_is_br,
        output alloc_ready, alloc_tag,
        input  wb_valid, wb_tag, wb_data, wb_mispred,
        input  q_tag,
        output q_ready, q_data,
        output commit_valid, commit_dest, commit_data, commit_tag, flush, count
    );

endinterface

// File: rtl/rob_wb_arbiter.sv
// Priority select across the CDB writeback ports for one ROB tag.
//   wb_valid / wb_tag : per-port writeback request and target tag (flattened)
//   sel_tag           : tag this instance watches
//   hit               : at least one valid port targets sel_tag
//   port              : index of the lowest-numbered hitting port
module rob_wb_arbiter #(
    parameter int NUM_WB = 2,
    parameter int TAG_W  = 3,
    parameter int PORT_W = 1
) (
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [TAG_W-1:0]        sel_tag,
    output logic                    hit,
    output logic [PORT_W-1:0]       port
);

    // Scan from the highest port down so the lowest matching port is the last write.
    always_comb begin
        hit  = 1'b0;
        port = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == sel_tag)) begin
                hit  = 1'b1;
                port = PORT_W'(p);
            end
        end
    end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order CDB writeback,
// in-order single commit per cycle, full flush on a committing mispredicted branch.
//   clk1  : sole clock, rising edge
//   rst_n : asynchronous active-low reset, discards all entries
//   rob   : slave side of rob_param_if (alloc, writeback, lookup, commit, count)
module rob_param
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DATA_W = ROB_DATA_W,
    parameter int REG_W  = ROB_REG_W,
    parameter int NUM_WB = ROB_NUM_WB,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic        clk1,
    input  logic        rst_n,
    rob_param_if.slave  rob
);

    localparam int PORT_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [TAG_W:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    ptr_t              head_q;
    ptr_t              tail_q;
    logic [TAG_W:0]    count_q;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_br;
    logic [DEPTH-1:0]  ent_mis;
    logic [REG_W-1:0]  ent_dest [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic              full;
    logic              commit_valid;
    logic              flush;
    logic              alloc_ready;
    logic              alloc_fire;

    logic [DEPTH-1:0]  wb_hit;
    logic [PORT_W-1:0] wb_port     [DEPTH];
    logic [DATA_W-1:0] wb_sel_data [DEPTH];
    logic [DEPTH-1:0]  wb_sel_mis;

    logic              q_hit;
    logic [PORT_W-1:0] q_port;

    assign head_idx     = head_q[TAG_W-1:0];
    assign tail_idx     = tail_q[TAG_W-1:0];
    assign full         = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign commit_valid = ent_valid[head_idx] && ent_done[head_idx];
    assign flush        = commit_valid && ent_br[head_idx] && ent_mis[head_idx];
    // No bypass of the slot freed by a same-cycle commit.
    assign alloc_ready  = !full && !flush;
    assign alloc_fire   = rob.alloc_valid && alloc_ready;

    // One arbiter per entry for the writeback update path.
    for (genvar e = 0; e < DEPTH; e++) begin : g_wb_arb
        rob_wb_arbiter #(
            .NUM_WB (NUM_WB),
            .TAG_W  (TAG_W),
            .PORT_W (PORT_W)
        ) u_wb_arb (
            .wb_valid (rob.wb_valid),
            .wb_tag   (rob.wb_tag),
            .sel_tag  (TAG_W'(e)),
            .hit      (wb_hit[e]),
            .port     (wb_port[e])
        );
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wb_sel_data[e] = rob.wb_data[int'(wb_port[e])*DATA_W +: DATA_W];
            wb_sel_mis[e]  = rob.wb_mispred[wb_port[e]];
        end
    end

    // Same arbiter reused for the operand-lookup bypass.
    rob_wb_arbiter #(
        .NUM_WB (NUM_WB),
        .TAG_W  (TAG_W),
        .PORT_W (PORT_W)
    ) u_q_arb (
        .wb_valid (rob.wb_valid),
        .wb_tag   (rob.wb_tag),
        .sel_tag  (rob.q_tag),
        .hit      (q_hit),
        .port     (q_port)
    );

    // A done entry ignores further writebacks, so its stored value takes precedence.
    always_comb begin
        rob.q_ready = 1'b0;
        rob.q_data  = '0;
        if (ent_done[rob.q_tag]) begin
            rob.q_ready = 1'b1;
            rob.q_data  = ent_data[rob.q_tag];
        end else if (q_hit) begin
            rob.q_ready = 1'b1;
            rob.q_data  = rob.wb_data[int'(q_port)*DATA_W +: DATA_W];
        end
    end

    assign rob.alloc_ready  = alloc_ready;
    assign rob.alloc_tag    = tail_idx;
    assign rob.commit_valid = commit_valid;
    assign rob.commit_dest  = commit_valid ? ent_dest[head_idx] : '0;
    assign rob.commit_data  = commit_valid ? ent_data[head_idx] : '0;
    assign rob.commit_tag   = commit_valid ? head_idx : '0;
    assign rob.flush        = flush;
    assign rob.count        = count_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_br    <= '0;
            ent_mis   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_dest[e] <= '0;
                ent_data[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wb_hit[e] && ent_valid[e] && !ent_done[e]) begin
                    ent_done[e] <= 1'b1;
                    ent_data[e] <= wb_sel_data[e];
                    ent_mis[e]  <= wb_sel_mis[e];
                end
            end

            if (commit_valid) begin
                ent_valid[head_idx] <= 1'b0;
                head_q              <= head_q + PTR_ONE;
            end

            // The tail entry is never valid here, so no writeback can collide with it.
            if (alloc_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                ent_mis[tail_idx]   <= 1'b0;
                ent_br[tail_idx]    <= rob.alloc_is_br;
                ent_dest[tail_idx]  <= rob.alloc_dest;
                tail_q              <= tail_q + PTR_ONE;
            end

            // Flush overrides everything: restart empty just past the branch.
            if (flush) begin
                ent_valid <= '0;
                tail_q    <= head_q + PTR_ONE;
                count_q   <= '0;
            end else begin
                count_q <= count_q + {{TAG_W{1'b0}}, alloc_fire}
                                   - {{TAG_W{1'b0}}, commit_valid};
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
module tb_rob_param;
    import tomasulo_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int REG_W  = 4;
    localparam int NUM_WB = 2;
    localparam int TAG_W  = 3;

    logic clk1 = 1'b0;
    logic rst_n;

    always #5 clk1 = ~clk1;

    rob_param_if #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .NUM_WB(NUM_WB), .TAG_W(TAG_W)
    ) bus ();

    rob_param #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .NUM_WB(NUM_WB), .TAG_W(TAG_W)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .rob   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: tags in allocation order; expected commit fields kept per tag.
    int sb [$];
    bit mdl_valid [DEPTH];
    bit mdl_done  [DEPTH];
    bit mdl_br    [DEPTH];
    bit mdl_mis   [DEPTH];
    int mdl_dest  [DEPTH];
    int mdl_data  [DEPTH];
    int m_tail;
    int m_count;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.alloc_dest  = '0;
        bus.alloc_is_br = 1'b0;
        bus.wb_valid    = '0;
        bus.wb_tag      = '0;
        bus.wb_data     = '0;
        bus.wb_mispred  = '0;
        bus.q_tag       = '0;
    endtask

    task automatic set_alloc(input int dest, input bit br);
        bus.alloc_valid = 1'b1;
        bus.alloc_dest  = REG_W'(dest);
        bus.alloc_is_br = br;
    endtask

    task automatic set_wb(input int p, input int tag, input int data, input bit mis);
        bus.wb_valid[p]                 = 1'b1;
        bus.wb_tag[p*TAG_W +: TAG_W]    = TAG_W'(tag);
        bus.wb_data[p*DATA_W +: DATA_W] = DATA_W'(data);
        bus.wb_mispred[p]               = mis;
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < DEPTH; i++) begin
            mdl_valid[i] = 0; mdl_done[i] = 0; mdl_br[i] = 0; mdl_mis[i] = 0;
            mdl_dest[i] = 0; mdl_data[i] = 0;
        end
        m_tail  = 0;
        m_count = 0;
    endtask

    // Checks this cycle's outputs against the scoreboard, advances the model, then clocks.
    task automatic cycle();
        bit exp_cv, exp_fl, exp_ar;
        int h;
        bit wrote [DEPTH];
        #1;
        exp_cv = (sb.size() > 0) && mdl_done[sb[0]];
        h      = exp_cv ? sb[0] : 0;
        exp_fl = exp_cv && mdl_br[h] && mdl_mis[h];
        exp_ar = (m_count < DEPTH) && !exp_fl;
        chk("count", 32'(bus.count), m_count);
        chk("commit_valid", 32'(bus.commit_valid), 32'(exp_cv));
        chk("flush", 32'(bus.flush), 32'(exp_fl));
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(exp_ar));
        chk("alloc_tag", 32'(bus.alloc_tag), m_tail);
        if (exp_cv && bus.commit_valid) begin
            chk("commit_tag", 32'(bus.commit_tag), h);
            chk("commit_dest", 32'(bus.commit_dest), mdl_dest[h]);
            chk("commit_data", 32'(bus.commit_data), mdl_data[h]);
        end
        for (int i = 0; i < DEPTH; i++) wrote[i] = 0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (bus.wb_valid[p]) begin
                int t;
                t = int'(bus.wb_tag[p*TAG_W +: TAG_W]);
                if (mdl_valid[t] && !mdl_done[t] && !wrote[t]) begin
                    wrote[t]    = 1;
                    mdl_done[t] = 1;
                    mdl_data[t] = int'(bus.wb_data[p*DATA_W +: DATA_W]);
                    mdl_mis[t]  = bus.wb_mispred[p];
                end
            end
        end
        if (exp_cv) begin
            void'(sb.pop_front());
            mdl_valid[h] = 0;
            m_count--;
        end
        if (bus.alloc_valid && exp_ar) begin
            mdl_valid[m_tail] = 1;
            mdl_done[m_tail]  = 0;
            mdl_mis[m_tail]   = 0;
            mdl_br[m_tail]    = bus.alloc_is_br;
            mdl_dest[m_tail]  = int'(bus.alloc_dest);
            sb.push_back(m_tail);
            m_tail = (m_tail + 1) % DEPTH;
            m_count++;
        end
        if (exp_fl) begin
            sb.delete();
            for (int i = 0; i < DEPTH; i++) mdl_valid[i] = 0;
            m_tail  = (h + 1) % DEPTH;
            m_count = 0;
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            idle();
            cycle();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_commit_valid", 32'(bus.commit_valid), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
        chk("rst_alloc_tag", 32'(bus.alloc_tag), 0);
        chk("rst_q_ready", 32'(bus.q_ready), 0);
        chk("rst_q_data", 32'(bus.q_data), 0);
        chk("rst_commit_dest", 32'(bus.commit_dest), 0);
        chk("rst_commit_data", 32'(bus.commit_data), 0);
        chk("rst_commit_tag", 32'(bus.commit_tag), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Fill: dest 1..8 land on tags 0..7; a ninth request is refused.
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            set_alloc(i + 1, 0);
            cycle();
        end
        chk("fill_count", 32'(bus.count), 8);
        chk("fill_ready", 32'(bus.alloc_ready), 0);
        idle();
        set_alloc(9, 0);
        cycle();

        // Out-of-order writeback; a second write to done tag 2 is ignored.
        idle(); set_wb(CDB_ADD, 2, 'h22, 0); cycle();
        idle(); set_wb(CDB_MUL, 2, 'h99, 0); cycle();
        idle(); set_wb(CDB_ADD, 0, 'h20, 0); cycle();
        // Tag 0 commits here while full; the allocation must still be refused.
        idle(); set_wb(CDB_MUL, 1, 'h21, 0); set_alloc(9, 0); cycle();
        idle(); cycle();
        idle(); cycle();
        chk("ooo_count", 32'(bus.count), 5);

        // Dual-port conflict on tag 3: port 0 wins, also through the lookup bypass.
        idle();
        set_wb(CDB_ADD, 3, 'h33, 0);
        set_wb(CDB_MUL, 3, 'h44, 0);
        bus.q_tag = 3'd3;
        #1;
        chk("conflict_q_ready", 32'(bus.q_ready), 1);
        chk("conflict_q_data", 32'(bus.q_data), 'h33);
        cycle();
        idle();
        bus.q_tag = 3'd4;
        #1;
        chk("pending_q_ready", 32'(bus.q_ready), 0);
        chk("pending_q_data", 32'(bus.q_data), 0);
        cycle();
        idle(); set_wb(CDB_ADD, 4, 'h44, 0); set_wb(CDB_MUL, 5, 'h45, 0); cycle();
        idle(); set_wb(CDB_MUL, 6, 'h46, 0); set_wb(CDB_ADD, 7, 'h47, 0);
        bus.q_tag = 3'd5;
        #1;
        chk("done_q_ready", 32'(bus.q_ready), 1);
        chk("done_q_data", 32'(bus.q_data), 'h45);
        cycle();
        drain(20);

        // Mispredicted branch at tag 0 with three younger entries behind it.
        idle(); set_alloc(10, 1); cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); set_alloc(11 + i, 0); cycle();
        end
        idle(); set_wb(CDB_ADD, 0, 'h55, 1); set_wb(CDB_MUL, 2, 'h66, 0); cycle();
        idle(); set_alloc(14, 0);
        #1;
        chk("flush_commit_valid", 32'(bus.commit_valid), 1);
        chk("flush_flag", 32'(bus.flush), 1);
        chk("flush_alloc_ready", 32'(bus.alloc_ready), 0);
        cycle();
        chk("post_flush_count", 32'(bus.count), 0);
        chk("post_flush_tag", 32'(bus.alloc_tag), 1);
        // Writebacks to flushed entries must not revive them.
        idle(); set_wb(CDB_ADD, 1, 'h77, 0); set_wb(CDB_MUL, 2, 'h78, 0); cycle();
        idle(); cycle();

        // Reset with five entries pending and the head already written.
        for (int i = 0; i < 5; i++) begin
            idle(); set_alloc(i + 1, 0); cycle();
        end
        idle(); set_wb(CDB_ADD, 1, 'h31, 0); set_wb(CDB_MUL, 2, 'h32, 0); cycle();
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(bus.count), 0);
        chk("midrst_commit_valid", 32'(bus.commit_valid), 0);
        chk("midrst_alloc_tag", 32'(bus.alloc_tag), 0);
        model_reset();
        @(negedge clk1);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle(); cycle();
        end

        // Wrap-around: 12 alloc/writeback/commit rounds.
        for (int i = 0; i < 12; i++) begin
            chk("wrap_alloc_tag", 32'(bus.alloc_tag), i % DEPTH);
            chk("wrap_count", 32'(bus.count), 0);
            idle(); set_alloc((i + 1) % 16, 0); cycle();
            idle(); set_wb(i % NUM_WB, i % DEPTH, 'h80 + i, 0); cycle();
            idle(); cycle();
        end
        chk("wrap_final_tag", 32'(bus.alloc_tag), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
